// File: rtl/step_pulse_shaper.sv
// Step/direction pulse shaper for a stepper driver.
// Turns rising edges on cmd[0] into clean step pulses with guaranteed
// direction setup, high and low times. It keeps a signed step count,
// refuses steps into an active endstop, and queues at most one request.
module step_pulse_shaper #(
    parameter int DIR_SETUP_CYC = 100,
    parameter int PULSE_HI_CYC  = 100,
    parameter int PULSE_LO_CYC  = 100
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [2:0]  cmd,
    input  logic        min_stop,
    input  logic        max_stop,
    output logic        motor_step,
    output logic        motor_dir,
    output logic        motor_en_n,
    output logic [31:0] position,
    output logic        busy,
    output logic        step_blocked,
    output logic        step_overrun
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DIR_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE_HI  = 2'd2;
    localparam logic [1:0] ST_PULSE_LO  = 2'd3;

    // Counters run from N-1 down to 0, so each state lasts exactly N cycles.
    localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP_CYC - 1);
    localparam logic [31:0] HI_LOAD    = 32'(PULSE_HI_CYC - 1);
    localparam logic [31:0] LO_LOAD    = 32'(PULSE_LO_CYC - 1);

    // Input capture and synchronizers
    logic [2:0]  cmd_q;
    logic        step_prev_q;
    logic        req_q;
    logic        min_meta_q, min_sync_q;
    logic        max_meta_q, max_sync_q;

    // Sequencer state
    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        step_q, step_d;
    logic        dir_q, dir_d;
    logic [31:0] pos_q, pos_d;
    logic        pend_q, pend_d;
    logic        blocked_q, blocked_d;
    logic        overrun_q, overrun_d;

    logic        enabled;
    logic        req_v;
    logic        refuse;

    assign enabled = cmd_q[2];
    // A request only counts while the driver is enabled.
    assign req_v   = req_q & enabled;
    // Endstop check for the direction being requested right now.
    assign refuse  = cmd_q[1] ? max_sync_q : min_sync_q;

    // Next-state logic for the step sequencer and the pending/overrun bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        pos_d     = pos_q;
        pend_d    = pend_q;
        blocked_d = 1'b0;
        overrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enabled && (req_v || pend_q)) begin
                    if (refuse) begin
                        blocked_d = 1'b1;
                    end else if (cmd_q[1] != dir_q) begin
                        dir_d   = cmd_q[1];
                        state_d = ST_DIR_SETUP;
                        cnt_d   = SETUP_LOAD;
                    end else begin
                        state_d = ST_PULSE_HI;
                        cnt_d   = HI_LOAD;
                    end
                end
            end
            ST_DIR_SETUP: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_PULSE_HI;
                    cnt_d   = HI_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_PULSE_HI: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_PULSE_LO;
                    cnt_d   = LO_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
        endcase

        // The step count moves on the edge that raises motor_step.
        if (state_d == ST_PULSE_HI && state_q != ST_PULSE_HI) begin
            pos_d = pos_q + (dir_d ? 32'd1 : 32'hFFFF_FFFF);
        end

        // Pending slot: in IDLE any waiting request is consumed this cycle, so a
        // request arriving now simply takes its place. Elsewhere a second
        // request while one is queued is dropped and flagged.
        if (!enabled) begin
            pend_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            pend_d = req_v & pend_q;
        end else if (req_v) begin
            if (pend_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    assign step_d = (state_d == ST_PULSE_HI);

    // All registers, synchronous active-low reset.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            cmd_q       <= 3'b000;
            step_prev_q <= 1'b0;
            req_q       <= 1'b0;
            min_meta_q  <= 1'b0;
            min_sync_q  <= 1'b0;
            max_meta_q  <= 1'b0;
            max_sync_q  <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            pos_q       <= 32'd0;
            pend_q      <= 1'b0;
            blocked_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cmd_q       <= cmd;
            step_prev_q <= cmd_q[0];
            req_q       <= cmd_q[0] & ~step_prev_q;
            min_meta_q  <= min_stop;
            min_sync_q  <= min_meta_q;
            max_meta_q  <= max_stop;
            max_sync_q  <= max_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            pend_q      <= pend_d;
            blocked_q   <= blocked_d;
            overrun_q   <= overrun_d;
        end
    end

    assign motor_step   = step_q;
    assign motor_dir    = dir_q;
    assign motor_en_n   = ~cmd_q[2];
    assign position     = pos_q;
    assign busy         = (state_q != ST_IDLE) | pend_q;
    assign step_blocked = blocked_q;
    assign step_overrun = overrun_q;

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Bench for step_pulse_shaper: reset values, a table of single-request
// vectors, hand-written multi-cycle sequences, and randomized requests
// checked against a request-level model of the shaper.
module tb_step_pulse_shaper;

  localparam int SETUP = 4;
  localparam int HI    = 3;
  localparam int LO    = 3;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cmd;
  logic        min_stop, max_stop;
  logic        motor_step, motor_dir, motor_en_n;
  logic [31:0] position;
  logic        busy, step_blocked, step_overrun;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pos;
  logic        m_dir;

  // monitor state
  int cyc = 0;
  int rises = 0, blk_cnt = 0, ovr_cnt = 0;
  int rise_cyc = 0, cur_w = 0, last_w = 0;
  logic mon_prev = 1'b0;

  step_pulse_shaper #(
    .DIR_SETUP_CYC(SETUP),
    .PULSE_HI_CYC(HI),
    .PULSE_LO_CYC(LO)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .cmd(cmd),
    .min_stop(min_stop),
    .max_stop(max_stop),
    .motor_step(motor_step),
    .motor_dir(motor_dir),
    .motor_en_n(motor_en_n),
    .position(position),
    .busy(busy),
    .step_blocked(step_blocked),
    .step_overrun(step_overrun)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (motor_step && !mon_prev) begin
      rises++;
      rise_cyc = cyc;
      cur_w = 0;
    end
    if (motor_step) cur_w++;
    if (!motor_step && mon_prev) last_w = cur_w;
    mon_prev = motor_step;
    if (step_blocked) blk_cnt++;
    if (step_overrun) ovr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one isolated request followed by enough idle time to complete
  task automatic run_and_check(input string name, input logic dir, input logic en,
                               input logic minv, input logic maxv, input int exp_r,
                               input int exp_b, input int exp_lat,
                               input logic [31:0] exp_pos, input logic exp_mdir);
    int r0, b0, o0, k;
    cmd = {en, dir, 1'b0};
    min_stop = minv;
    max_stop = maxv;
    wait_neg(4);
    check({name, ".en_n"}, 32'(motor_en_n), 32'(!en));
    r0 = rises; b0 = blk_cnt; o0 = ovr_cnt;
    cmd[0] = 1'b1;
    k = cyc;
    wait_neg(25);
    cmd[0] = 1'b0;
    check({name, ".rises"}, 32'(rises - r0), 32'(exp_r));
    check({name, ".blocked"}, 32'(blk_cnt - b0), 32'(exp_b));
    check({name, ".overrun"}, 32'(ovr_cnt - o0), 32'd0);
    check({name, ".pos"}, position, exp_pos);
    check({name, ".dir"}, 32'(motor_dir), 32'(exp_mdir));
    check({name, ".busy"}, 32'(busy), 32'd0);
    if (exp_r == 1) begin
      check({name, ".latency"}, 32'(rise_cyc - (k + 1)), 32'(exp_lat));
      check({name, ".width"}, 32'(last_w), 32'(HI));
    end
    wait_neg(2);
  endtask

  typedef struct {
    logic        dir, en, minv, maxv;
    int          rises, blk, lat;
    logic [31:0] pos;
    logic        mdir;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int r0, o0, b0;
    logic dir, en, minv, maxv, eb, er;
    int lat;

    rst_n = 1'b0;
    cmd = 3'b000;
    min_stop = 1'b0;
    max_stop = 1'b0;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 2,         32'hFFFF_FFFF, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 2 + SETUP, 32'd0,         1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 2,         32'd1,         1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 2 + SETUP, 32'd0,         1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 0,         32'd0,         1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 0,         32'd0,         1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 2 + SETUP, 32'd1,         1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 2 + SETUP, 32'd0,         1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0,         32'd0,         1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 1, 0,         32'd0,         1'b0};

    // reset values
    wait_neg(3);
    check("rst.step", 32'(motor_step), 32'd0);
    check("rst.dir", 32'(motor_dir), 32'd0);
    check("rst.en_n", 32'(motor_en_n), 32'd1);
    check("rst.pos", position, 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.blocked", 32'(step_blocked), 32'd0);
    check("rst.overrun", 32'(step_overrun), 32'd0);
    rst_n = 1'b1;
    wait_neg(2);

    // table vectors
    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("tbl%0d", i), tbl[i].dir, tbl[i].en, tbl[i].minv, tbl[i].maxv,
                    tbl[i].rises, tbl[i].blk, tbl[i].lat, tbl[i].pos, tbl[i].mdir);
    end

    // three step edges during one sequence: run, pend, overrun
    cmd = 3'b110;
    min_stop = 1'b0;
    max_stop = 1'b0;
    wait_neg(4);
    r0 = rises; o0 = ovr_cnt;
    cmd[0] = 1'b1; wait_neg(1);
    cmd[0] = 1'b0; wait_neg(1);
    cmd[0] = 1'b1; wait_neg(1);
    cmd[0] = 1'b0; wait_neg(1);
    cmd[0] = 1'b1; wait_neg(1);
    check("triple.busy_mid", 32'(busy), 32'd1);
    wait_neg(40);
    cmd[0] = 1'b0;
    check("triple.rises", 32'(rises - r0), 32'd2);
    check("triple.overrun", 32'(ovr_cnt - o0), 32'd1);
    check("triple.pos", position, 32'd2);
    check("triple.busy_end", 32'(busy), 32'd0);
    wait_neg(4);

    // enable drops mid-pulse with a request pending
    r0 = rises; o0 = ovr_cnt;
    cmd[0] = 1'b1; wait_neg(1);
    cmd[0] = 1'b0; wait_neg(1);
    cmd[0] = 1'b1; wait_neg(2);
    cmd = 3'b000;
    wait_neg(30);
    check("endrop.rises", 32'(rises - r0), 32'd1);
    check("endrop.width", 32'(last_w), 32'(HI));
    check("endrop.overrun", 32'(ovr_cnt - o0), 32'd0);
    check("endrop.pos", position, 32'd3);
    check("endrop.busy", 32'(busy), 32'd0);
    check("endrop.en_n", 32'(motor_en_n), 32'd1);

    // position wrap from 0x7FFFFFFF
    force dut.pos_q = 32'h7FFF_FFFF;
    wait_neg(2);
    release dut.pos_q;
    run_and_check("wrap", 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 2, 32'h8000_0000, 1'b1);

    // reset in the middle of the high phase
    cmd = 3'b110;
    wait_neg(4);
    cmd[0] = 1'b1;
    wait_neg(3);
    check("midrst.step_before", 32'(motor_step), 32'd1);
    rst_n = 1'b0;
    wait_neg(1);
    check("midrst.step", 32'(motor_step), 32'd0);
    check("midrst.pos", position, 32'd0);
    check("midrst.en_n", 32'(motor_en_n), 32'd1);
    check("midrst.busy", 32'(busy), 32'd0);
    cmd = 3'b000;
    rst_n = 1'b1;
    wait_neg(3);
    m_pos = 32'd0;
    m_dir = 1'b0;

    // randomized requests against the request-level model
    for (int n = 0; n < 30; n++) begin
      dir  = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 9) < 8);
      minv = ($urandom_range(0, 3) == 0);
      maxv = ($urandom_range(0, 3) == 0);
      eb   = en && (dir ? maxv : minv);
      er   = en && !eb;
      lat  = 2 + ((dir != m_dir) ? SETUP : 0);
      if (er) begin
        m_pos = m_pos + (dir ? 32'd1 : 32'hFFFF_FFFF);
        m_dir = dir;
      end
      run_and_check($sformatf("rnd%0d", n), dir, en, minv, maxv,
                    er ? 1 : 0, eb ? 1 : 0, lat, m_pos, m_dir);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_pulse_shaper.md
STEP_PULSE_SHAPER -- requirements
Module: step_pulse_shaper

Interface
REQ-001 SHALL have parameter DIR_SETUP_CYC, default 100: cycles between a motor_dir change and the next motor_step rise.
REQ-002 SHALL have parameter PULSE_HI_CYC, default 100: motor_step high width in cycles.
REQ-003 SHALL have parameter PULSE_LO_CYC, default 100: minimum motor_step low time after each pulse, in cycles.
REQ-004 SHALL have port clk_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port cmd, input, 3: step_motor PIO export; bit0 = step request (rising edge), bit1 = dir (1 = positive), bit2 = enable.
REQ-007 SHALL have port min_stop, input, 1: asynchronous min endstop, active high.
REQ-008 SHALL have port max_stop, input, 1: asynchronous max endstop, active high.
REQ-009 SHALL have port motor_step, output, 1: step pulse to the driver.
REQ-010 SHALL have port motor_dir, output, 1: direction to the driver.
REQ-011 SHALL have port motor_en_n, output, 1: driver enable, active low.
REQ-012 SHALL have port position, output, 32: signed step count.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE, or while a request is pending.
REQ-014 SHALL have port step_blocked, output, 1: one-cycle pulse when a step is refused by an endstop.
REQ-015 SHALL have port step_overrun, output, 1: one-cycle pulse when a request is lost.

Function
REQ-016 SHALL register cmd once; step request = registered bit0 is 1 while its previous registered value was 0.
REQ-017 SHALL pass min_stop and max_stop through 2-flop synchronizers; endstop logic uses only the synchronized values.
REQ-018 SHALL drive motor_en_n = ~registered cmd[2].
REQ-019 SHALL ignore step requests while registered cmd[2] = 0.
REQ-020 SHALL implement FSM states IDLE, DIR_SETUP, PULSE_HI, PULSE_LO.
REQ-021 SHALL accept a request in IDLE (new or pending) using requested dir = registered cmd[1] at acceptance.
REQ-022 SHALL check the endstop at acceptance: dir=1 with max_stop=1, or dir=0 with min_stop=1, refuses the step.
REQ-023 SHALL, on refusal, pulse step_blocked, stay in IDLE, leave position and motor_dir unchanged, and consume the request.
REQ-024 SHALL, on acceptance with requested dir different from motor_dir, update motor_dir and enter DIR_SETUP for DIR_SETUP_CYC cycles, then enter PULSE_HI.
REQ-025 SHALL, on acceptance with requested dir equal to motor_dir, enter PULSE_HI directly.
REQ-026 SHALL hold motor_step high for exactly PULSE_HI_CYC cycles in PULSE_HI.
REQ-027 SHALL hold motor_step low for PULSE_LO_CYC cycles in PULSE_LO, then return to IDLE.
REQ-028 SHALL make motor_step rise exactly 2 cycles after the edge that first registers cmd[0]=1, when idle, enabled, unblocked and with no dir change.
REQ-029 SHALL add +1 (dir=1) or -1 (dir=0) to position on entry to PULSE_HI, with two's-complement wrap (0x7FFFFFFF+1 -> 0x80000000).
REQ-030 SHALL, on a request arriving outside IDLE, set a one-deep pending flag.
REQ-031 SHALL, on a request arriving while pending is already set, pulse step_overrun and drop the new request.
REQ-032 SHALL, on a request arriving in the same cycle that pending is consumed, treat it as a new pending request without overrun.
REQ-033 SHALL, if cmd[2] falls mid-operation, finish the current pulse sequence (no runt pulse) and clear pending without an overrun pulse.
REQ-034 SHALL let an endstop asserting after acceptance take no effect on the pulse in progress.

Reset
REQ-035 SHALL, while reset_reset_n=0 at a clock edge, set state=IDLE, motor_step=0, motor_dir=0, motor_en_n=1, position=0, busy=0, step_blocked=0, step_overrun=0, pending=0, and clear all synchronizers and the cmd register.
REQ-036 SHALL, on reset mid-pulse, force motor_step low on the next edge; there is no pulse completion.

Verification
REQ-037 SHALL cover: DIR_SETUP_CYC=4, PULSE_HI_CYC=3, PULSE_LO_CYC=3, cmd 3'b110 -> 3'b111, motor_dir already 1 -> motor_step high 3 cycles starting 2 cycles later, position=1.
REQ-038 SHALL cover: cmd 3'b101 step with motor_dir=1 -> motor_dir=0, 4 cycles later motor_step high, position decrements to -1 (0xFFFFFFFF).
REQ-039 SHALL cover: max_stop=1 held for 3+ cycles, dir=1 request -> step_blocked 1-cycle pulse, motor_step stays 0, position unchanged.
REQ-040 SHALL cover: three step edges during one pulse -> first executes, second pends and executes afterwards, third gives step_overrun, final position +2.
REQ-041 SHALL cover: position preloaded to 0x7FFFFFFF via 2^31-1 steps (or forced), one +step -> 0x80000000.
REQ-042 SHALL cover: reset_reset_n=0 during PULSE_HI -> next edge motor_step=0, position=0, motor_en_n=1.
